// File: rtl/otter_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : otter_dmem_ctrl
// Description : Data-memory controller for the Otter MCU data port.
//               - Word-wide on-chip RAM, byte-lane writes, 1-cycle registered
//                 read (read-first when a load and store coincide).
//               - MMIO window bridged onto a req/ack bus with a timeout.
//               - Unmapped accesses return 0 and pulse dmem_err.
// Ports       : clk, rst (sync, active-high)
//               dmem_r_en/w_en/w_strb/addr/w_data  -> request from core
//               dmem_r_data/busy/err               -> response to core
//               mmio_req/we/addr/wdata/strb        -> peripheral request
//               mmio_ack/rdata                     <- peripheral response
// Revision    : 1.0  initial release
// ============================================================================
module otter_dmem_ctrl #(
  parameter int unsigned RAM_WORDS    = 16384,
  parameter logic [31:0] RAM_BASE     = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE    = 32'h1100_0000,
  parameter logic [31:0] MMIO_SIZE    = 32'h0001_0000,
  parameter int unsigned MMIO_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_r_en,
  input  logic        dmem_w_en,
  input  logic [3:0]  dmem_w_strb,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_w_data,
  output logic [31:0] dmem_r_data,
  output logic        dmem_busy,
  output logic        dmem_err,
  output logic        mmio_req,
  output logic        mmio_we,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  output logic [3:0]  mmio_strb,
  input  logic        mmio_ack,
  input  logic [31:0] mmio_rdata
);

  localparam int unsigned     RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0]     RAM_BYTES = 32'(RAM_WORDS) << 2;
  localparam int unsigned     CNT_W     = $clog2(MMIO_TIMEOUT + 1);
  // The timeout fires in the WAIT cycle whose count is MMIO_TIMEOUT-1, so
  // mmio_req is high for exactly MMIO_TIMEOUT cycles when no ack arrives.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MMIO_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]      r_mem [RAM_WORDS];
  logic [31:0]      r_rdata;
  logic             r_err;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_strb;
  logic [CNT_W-1:0] r_cnt;

  logic              w_valid;
  logic [31:0]       w_ram_off;
  logic [31:0]       w_mmio_off;
  logic              w_in_ram;
  logic              w_in_mmio;
  logic              w_idle_acc;
  logic [RAM_AW-1:0] w_idx;
  logic              w_start;
  logic              w_ack_done;
  logic              w_timeout;

  // Address decode. Offsets wrap below the base, so a single unsigned
  // compare covers both window edges. RAM takes priority on overlap.
  assign w_valid    = dmem_r_en | dmem_w_en;
  assign w_ram_off  = dmem_addr - RAM_BASE;
  assign w_mmio_off = dmem_addr - MMIO_BASE;
  assign w_in_ram   = (w_ram_off < RAM_BYTES);
  assign w_in_mmio  = !w_in_ram && (w_mmio_off < MMIO_SIZE);
  assign w_idx      = dmem_addr[RAM_AW+1:2];
  assign w_idle_acc = (r_state == ST_IDLE) && w_valid;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state and busy
  always_comb begin
    w_state_nxt = r_state;
    dmem_busy   = 1'b0;
    w_start     = 1'b0;
    w_ack_done  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_valid && w_in_mmio) begin
          dmem_busy   = 1'b1;
          w_start     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        dmem_busy = 1'b1;
        // Ack is checked first so it wins over a coincident timeout.
        if (mmio_ack) begin
          w_ack_done  = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // The core still holds its request this cycle; it is retired here,
        // not re-issued.
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // RAM array: no reset, byte-lane writes only from IDLE.
  always_ff @(posedge clk) begin
    if (!rst && w_idle_acc && w_in_ram && dmem_w_en) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_w_strb[i]) r_mem[w_idx][8*i +: 8] <= dmem_w_data[8*i +: 8];
      end
    end
  end

  // Response and MMIO datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_strb  <= 4'h0;
      r_cnt   <= '0;
    end else begin
      r_err <= 1'b0;

      if (w_idle_acc && w_in_ram && dmem_r_en) begin
        r_rdata <= r_mem[w_idx];
      end

      if (w_idle_acc && !w_in_ram && !w_in_mmio) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b1;
      end

      if (w_start) begin
        r_req   <= 1'b1;
        r_we    <= dmem_w_en;
        r_addr  <= {dmem_addr[31:2], 2'b00};
        r_wdata <= dmem_w_data;
        r_strb  <= dmem_w_en ? dmem_w_strb : 4'b0000;
        r_cnt   <= '0;
      end

      if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_ack_done) begin
        r_req <= 1'b0;
        if (!r_we) r_rdata <= mmio_rdata;
      end

      if (w_timeout) begin
        r_req   <= 1'b0;
        r_rdata <= 32'hDEAD_DEAD;
        r_err   <= 1'b1;
      end
    end
  end

  assign dmem_r_data = r_rdata;
  assign dmem_err    = r_err;
  assign mmio_req    = r_req;
  assign mmio_we     = r_we;
  assign mmio_addr   = r_addr;
  assign mmio_wdata  = r_wdata;
  assign mmio_strb   = r_strb;

endmodule
`default_nettype wire

// File: tb/tb_otter_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_dmem_ctrl
// Description : Scoreboard bench for otter_dmem_ctrl. A reference model
//               computes each access result from the memory map; a monitor
//               checks responses at retirement, and a peripheral responder
//               checks MMIO request fields and burst lengths.
// Revision    : 1.0  initial release
// ============================================================================
module tb_otter_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_r_en = 1'b0, dmem_w_en = 1'b0;
  logic [3:0]  dmem_w_strb = 4'h0;
  logic [31:0] dmem_addr = 32'h0, dmem_w_data = 32'h0;
  logic [31:0] dmem_r_data;
  logic        dmem_busy, dmem_err;
  logic        mmio_req, mmio_we;
  logic [31:0] mmio_addr, mmio_wdata;
  logic [3:0]  mmio_strb;
  logic        mmio_ack = 1'b0;
  logic [31:0] mmio_rdata = 32'h0;

  otter_dmem_ctrl dut (
    .clk(clk), .rst(rst),
    .dmem_r_en(dmem_r_en), .dmem_w_en(dmem_w_en), .dmem_w_strb(dmem_w_strb),
    .dmem_addr(dmem_addr), .dmem_w_data(dmem_w_data),
    .dmem_r_data(dmem_r_data), .dmem_busy(dmem_busy), .dmem_err(dmem_err),
    .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_strb(mmio_strb),
    .mmio_ack(mmio_ack), .mmio_rdata(mmio_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata = 32'h0;
  int          ack_delay = 0;          // 0 = peripheral never acks
  logic [31:0] ack_rdata = 32'h0;

  typedef struct { logic [31:0] rdata; logic e0; logic e1; } exp_t;
  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic we; logic [3:0] strb; int len; } bus_t;
  exp_t sb_q[$];
  bus_t bus_q[$];

  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'h0001_0000;
  endfunction
  function automatic bit is_mmio(input logic [31:0] a);
    return (a >= 32'h1100_0000) && (a < 32'h1101_0000);
  endfunction

  // Issue one core access, hold it while busy, then leave one idle cycle.
  task automatic access(input bit r, input bit w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] wd, input int d);
    exp_t        e;
    bus_t        b;
    logic [31:0] word;
    int          key;
    int          exp_busy;
    int          busy_n;
    ack_delay = d;
    ack_rdata = $urandom;
    e.e0 = 1'b0; e.e1 = 1'b0; exp_busy = 0;
    if (is_ram(a)) begin
      key  = int'(a[15:2]);
      word = m_mem.exists(key) ? m_mem[key] : 32'hx;
      if (r) m_rdata = word;
      if (w) begin
        for (int i = 0; i < 4; i++) if (s[i]) word[8*i +: 8] = wd[8*i +: 8];
        m_mem[key] = word;
      end
    end else if (is_mmio(a)) begin
      b.addr = {a[31:2], 2'b00}; b.we = w; b.wdata = wd; b.strb = w ? s : 4'h0;
      if (d >= 1 && d <= 255) begin
        b.len = d; exp_busy = 1 + d;
        if (!w) m_rdata = ack_rdata;
      end else begin
        b.len = 255; exp_busy = 256;
        m_rdata = 32'hDEAD_DEAD; e.e0 = 1'b1;
      end
      bus_q.push_back(b);
    end else begin
      m_rdata = 32'h0; e.e1 = 1'b1;
    end
    e.rdata = m_rdata;
    sb_q.push_back(e);

    @(posedge clk); #1;
    dmem_r_en = r; dmem_w_en = w; dmem_w_strb = s; dmem_addr = a; dmem_w_data = wd;
    busy_n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!dmem_busy) break;
      busy_n++;
    end
    chk("busy_cycles", busy_n, exp_busy);
    @(posedge clk); #1;
    dmem_r_en = 1'b0; dmem_w_en = 1'b0;
  endtask

  // ---------------- response monitor ----------------
  bit   pend = 1'b0;
  logic e0_s;
  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      pend = 1'b0;
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow actual=retire required=none");
      end else begin
        e = sb_q.pop_front();
        chk("r_data", dmem_r_data, e.rdata);
        chk("err_retire_cycle", {31'h0, e0_s}, {31'h0, e.e0});
        chk("err_next_cycle", {31'h0, dmem_err}, {31'h0, e.e1});
      end
    end
    if (!rst && (dmem_r_en || dmem_w_en) && !dmem_busy) begin
      pend = 1'b1;
      e0_s = dmem_err;
    end
  end

  // ---------------- peripheral responder ----------------
  int   rcnt = 0;
  bus_t cur;
  always @(negedge clk) begin
    if (mmio_req) begin
      if (rcnt == 0) begin
        if (bus_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL bus_unexpected_req actual=req required=none");
          cur.addr = 32'h0; cur.wdata = 32'h0; cur.we = 1'b0; cur.strb = 4'h0; cur.len = 0;
        end else cur = bus_q.pop_front();
      end
      chk("mmio_addr", mmio_addr, cur.addr);
      chk("mmio_we", {31'h0, mmio_we}, {31'h0, cur.we});
      chk("mmio_wdata", mmio_wdata, cur.wdata);
      chk("mmio_strb", {28'h0, mmio_strb}, {28'h0, cur.strb});
      rcnt++;
      mmio_ack   = (rcnt == ack_delay);
      mmio_rdata = mmio_ack ? ack_rdata : $urandom;
    end else begin
      if (rcnt != 0) begin
        chk("mmio_req_cycles", rcnt, cur.len);
        rcnt = 0;
      end
      // Stray acks outside WAIT must be ignored by the controller.
      mmio_ack   = 1'($urandom_range(0, 1));
      mmio_rdata = $urandom;
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] ram_pool [12] = '{32'h0, 32'h4, 32'h10, 32'h14, 32'h100, 32'h1FFC,
                                 32'h2000, 32'h7FF0, 32'h8000, 32'hABC4, 32'hFFF8, 32'hFFFC};
  logic [31:0] bad_pool [6]  = '{32'h8000_0000, 32'h0001_0000, 32'h0001_0010,
                                 32'h1101_0000, 32'h10FF_FFFC, 32'hFFFF_FFFC};

  initial begin
    int sel, rw, d;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_r_data", dmem_r_data, 32'h0);
    chk("rst_busy", {31'h0, dmem_busy}, 32'h0);
    chk("rst_err", {31'h0, dmem_err}, 32'h0);
    chk("rst_mmio_req", {31'h0, mmio_req}, 32'h0);
    chk("rst_mmio_we", {31'h0, mmio_we}, 32'h0);
    chk("rst_mmio_addr", mmio_addr, 32'h0);
    chk("rst_mmio_wdata", mmio_wdata, 32'h0);
    chk("rst_mmio_strb", {28'h0, mmio_strb}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (ram_pool[i]) access(0, 1, 4'hF, ram_pool[i], $urandom, 0);

    // Directed cases
    access(0, 1, 4'hF, 32'h10, 32'hAABB_CCDD, 0);
    access(1, 0, 4'h0, 32'h10, 32'h0, 0);
    access(0, 1, 4'b0100, 32'h10, 32'h00EE_0000, 0);
    access(1, 0, 4'h0, 32'h10, 32'h0, 0);
    access(1, 1, 4'b0011, 32'h10, 32'h0000_1234, 0);    // read-first
    access(1, 0, 4'h0, 32'h1100_0004, 32'h0, 3);
    access(0, 1, 4'hF, 32'h1100_0008, 32'h5555_AAAA, 0); // timeout
    access(1, 0, 4'h0, 32'h1100_000C, 32'h0, 255);       // ack meets timeout
    access(1, 0, 4'h0, 32'h8000_0000, 32'h0, 0);
    access(0, 1, 4'hF, 32'h0001_0010, 32'hFFFF_FFFF, 0);
    access(1, 0, 4'h0, 32'h10, 32'h0, 0);
    access(1, 0, 4'h0, 32'h1100_FFFC, 32'h0, 1);
    access(0, 1, 4'h9, 32'h1100_0001, 32'h1357_9BDF, 2);
    access(1, 0, 4'h0, 32'h1101_0000, 32'h0, 0);
    access(1, 0, 4'h0, 32'h10FF_FFFC, 32'h0, 0);

    // Reset during the second WAIT cycle
    begin
      bus_t b;
      b.addr = 32'h1100_0020; b.we = 1'b0; b.wdata = 32'h0; b.strb = 4'h0; b.len = 2;
      bus_q.push_back(b);
      ack_delay = 0;
      @(posedge clk); #1;
      dmem_r_en = 1'b1; dmem_addr = 32'h1100_0020; dmem_w_data = 32'h0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1; dmem_r_en = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      m_rdata = 32'h0;
      @(negedge clk);
      chk("rst_wait_req", {31'h0, mmio_req}, 32'h0);
      chk("rst_wait_busy", {31'h0, dmem_busy}, 32'h0);
      chk("rst_wait_r_data", dmem_r_data, 32'h0);
      access(1, 0, 4'h0, 32'h10, 32'h0, 0);
    end

    // Randomized mix
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 19);
      rw  = $urandom_range(0, 2);
      if (sel < 12)      a = ram_pool[$urandom_range(0, 11)] | 32'($urandom_range(0, 3));
      else if (sel < 17) a = 32'h1100_0000 | 32'($urandom_range(0, 32'hFFFF));
      else               a = bad_pool[$urandom_range(0, 5)];
      d = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
      access(rw != 1, rw != 0, 4'($urandom), a, $urandom, d);
    end

    repeat (4) @(posedge clk);
    chk("sb_left", sb_q.size(), 32'h0);
    chk("bus_left", bus_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
